// File: rtl/reg_writeback_queue.sv
// Register writeback queue: buffers results until the register file write port frees up.
// Define WB_BYPASS_EN to enable lookup/forwarding of pending writes.
module reg_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_addr,
  input  logic [31:0] in_data,
  input  logic        stall,
  output logic        we,
  output logic [4:0]  addr_rd2,
  output logic [31:0] data_rd2,
  input  logic [4:0]  lookup_addr0,
  input  logic [4:0]  lookup_addr1,
  output logic        hit0,
  output logic        hit1,
  output logic [31:0] hit_data0,
  output logic [31:0] hit_data1,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [4:0]    addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;

  logic push;
  logic pop;
  logic empty;

  assign empty     = (count == '0);
  assign in_ready  = (count != FULL) & ~rst;
  assign pop       = ~empty & ~stall & ~rst;
  // Writes to x0 are accepted but never enqueued.
  assign push      = in_valid & in_ready & (in_addr != 5'd0);
  assign we        = pop;
  assign occupancy = count;
  assign addr_rd2  = empty ? 5'd0 : addr_q[head];
  assign data_rd2  = empty ? 32'd0 : data_q[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        addr_q[tail] <= in_addr;
        data_q[tail] <= in_data;
        tail         <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the last match is the youngest entry.
  always_comb begin
    hit0      = 1'b0;
    hit1      = 1'b0;
    hit_data0 = 32'd0;
    hit_data1 = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((AW+1)'(i) < count) begin
        if (lookup_addr0 != 5'd0 &&
            addr_q[head + AW'(i)] == lookup_addr0) begin
          hit0      = 1'b1;
          hit_data0 = data_q[head + AW'(i)];
        end
        if (lookup_addr1 != 5'd0 &&
            addr_q[head + AW'(i)] == lookup_addr1) begin
          hit1      = 1'b1;
          hit_data1 = data_q[head + AW'(i)];
        end
      end
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^{lookup_addr0, lookup_addr1};
  assign hit0      = 1'b0;
  assign hit1      = 1'b0;
  assign hit_data0 = 32'd0;
  assign hit_data1 = 32'd0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue (DEPTH=4).
// Bypass expectations follow WB_BYPASS_EN when it is defined for the build.
module tb_reg_writeback_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        stall;
  logic        we;
  logic [4:0]  addr_rd2;
  logic [31:0] data_rd2;
  logic [4:0]  lookup_addr0;
  logic [4:0]  lookup_addr1;
  logic        hit0;
  logic        hit1;
  logic [31:0] hit_data0;
  logic [31:0] hit_data1;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  reg_writeback_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data),
    .stall(stall), .we(we),
    .addr_rd2(addr_rd2), .data_rd2(data_rd2),
    .lookup_addr0(lookup_addr0), .lookup_addr1(lookup_addr1),
    .hit0(hit0), .hit1(hit1),
    .hit_data0(hit_data0), .hit_data1(hit_data1),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  logic [36:0] exp_q[$];
  int pushed;
  int writes;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    stall = 1'b0; lookup_addr0 = '0; lookup_addr1 = '0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we", we, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("por_occ", occupancy, 0);
    chk("por_we", we, 0);
    chk("por_addr", addr_rd2, 0);
    chk("por_data", data_rd2, 0);
    chk("por_hit0", hit0, 0);
    chk("por_hit_data1", hit_data1, 0);
    chk("por_in_ready", in_ready, 1);

    // single write, no cut-through
    in_valid = 1'b1; in_addr = 5'd5; in_data = 32'hDEADBEEF;
    #1;
    chk("single_nocut_we", we, 0);
    tick();
    in_valid = 1'b0;
    chk("single_we", we, 1);
    chk("single_addr", addr_rd2, 5);
    chk("single_data", data_rd2, 32'hDEADBEEF);
    tick();
    chk("single_we_after", we, 0);
    chk("single_occ_after", occupancy, 0);

    // x0 write is consumed but discarded
    in_valid = 1'b1; in_addr = 5'd0; in_data = 32'hFFFFFFFF;
    #1;
    chk("x0_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("x0_occ", occupancy, 0);
    chk("x0_we", we, 0);
    tick();
    chk("x0_we_later", we, 0);

    // fill while stalled, then drain
    stall = 1'b1;
    push(5'd1, 32'h11); push(5'd2, 32'h22);
    push(5'd3, 32'h33); push(5'd4, 32'h44);
    chk("full_occ", occupancy, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_we", we, 0);
    push(5'd5, 32'h55);
    chk("full_fifth_ignored", occupancy, 4);
    stall = 1'b0;
    #1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain%0d_we", i), we, 1);
      chk($sformatf("drain%0d_addr", i), addr_rd2, i);
      chk($sformatf("drain%0d_data", i), data_rd2, 32'h11 * i);
      tick();
    end
    chk("drain_we_end", we, 0);
    chk("drain_occ_end", occupancy, 0);

    // duplicate addresses: lookup sees youngest value
    stall = 1'b1;
    push(5'd7, 32'hAAAA0001);
    push(5'd7, 32'hAAAA0002);
    lookup_addr0 = 5'd7; lookup_addr1 = 5'd0;
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_hit0", hit0, 1);
    chk("byp_hit_data0", hit_data0, 32'hAAAA0002);
`else
    chk("byp_hit0", hit0, 0);
    chk("byp_hit_data0", hit_data0, 0);
`endif
    chk("byp_hit1", hit1, 0);
    chk("byp_hit_data1", hit_data1, 0);
    stall = 1'b0;
    #1;
    chk("dup_first_addr", addr_rd2, 7);
    chk("dup_first_data", data_rd2, 32'hAAAA0001);
    tick();
    chk("dup_second_data", data_rd2, 32'hAAAA0002);
`ifdef WB_BYPASS_EN
    chk("byp_head_hit0", hit0, 1);
`else
    chk("byp_head_hit0", hit0, 0);
`endif
    tick();
    chk("dup_occ_end", occupancy, 0);
    chk("byp_hit0_empty", hit0, 0);
    lookup_addr0 = 5'd0;

    // reset flushes a full queue
    stall = 1'b1;
    push(5'd10, 32'hA); push(5'd11, 32'hB);
    push(5'd12, 32'hC); push(5'd13, 32'hD);
    chk("rfl_occ_full", occupancy, 4);
    rst = 1'b1; stall = 1'b0;
    in_valid = 1'b1; in_addr = 5'd9; in_data = 32'h9;
    #1;
    chk("rfl_we", we, 0);
    chk("rfl_in_ready", in_ready, 0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rfl_occ", occupancy, 0);
    chk("rfl_we_after", we, 0);
    tick();
    chk("rfl_we_later", we, 0);

    // 10 pushes, stall toggling every other cycle, pointer wrap
    pushed = 0;
    writes = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (pushed == 10 && exp_q.size() == 0) break;
      stall    = ((cyc / 2) % 2) == 1;
      in_valid = (pushed < 10);
      in_addr  = 5'(pushed + 1);
      in_data  = 32'hC0DE0000 + pushed;
      #1;
      if (we) begin
        if (exp_q.size() == 0) begin
          chk("wrap_spurious_we", we, 0);
        end else begin
          chk($sformatf("wrap_w%0d", writes), {addr_rd2, data_rd2},
              exp_q[0]);
          void'(exp_q.pop_front());
          writes++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_addr, in_data});
        pushed++;
      end
      tick();
      in_valid = 1'b0;
      chk("wrap_occ_model", occupancy, exp_q.size());
      chk("wrap_occ_max", occupancy <= 3'd4, 1);
    end
    chk("wrap_pushes", pushed, 10);
    chk("wrap_writes", writes, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
